genius_seq_engine: RTL and testbench
====================================

Name: genius_seq_engine

Overview:
- Parametrised sequence engine for the Genius (Simon) game.
- Generates a game sequence into internal memory, plays the first limit+1 entries on the LEDs with fixed on/off timing, then checks the player's button presses against that sequence with a per-press timeout.
- Sits between the button/LED I/O and the top-level game controller. The controller only issues start and reads round/win/lose status.
- Replaces fixed two-ROM storage with LFSR or deterministic generation, N buttons, configurable depth and timing.

Parameters:
- N_BTN, 4: number of buttons/LEDs, 2..7.
- DEPTH, 16: maximum sequence length (power of 2).
- ADDR_W, 4: log2(DEPTH).
- T_ON, 1000: cycles an LED stays lit during playback.
- T_OFF, 500: dark cycles between playback steps.
- T_TIMEOUT, 5000: maximum cycles allowed between presses.
- LFSR_SEED, 16'hACE1: LFSR reset value, must be nonzero.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a game. Sampled in IDLE, WIN, LOSE.
- mode_random  in  1  1 = LFSR sequence; 0 = deterministic one-hot(i mod N_BTN). Sampled at start.
- botoes  in  N_BTN  raw button levels, already synchronised.
- leds  out  N_BTN  LED drive.
- busy  out  1  high in any state except IDLE/WIN/LOSE.
- player_turn  out  1  high in WAIT_PLAY.
- round_ok  out  1  one-cycle pulse when a full round is entered correctly.
- win  out  1  level, high in WIN.
- lose  out  1  level, high in LOSE.
- timeout  out  1  level, high in LOSE when entered by timeout.
- db_limite  out  ADDR_W  current round limit.
- db_endereco  out  ADDR_W  current sequence address.
- db_estado  out  4  state code.

Behaviour:
- Reset: state IDLE; all outputs 0; limit=0; addr=0; LFSR=LFSR_SEED. Memory contents are undefined and are never read before GEN.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Free-runs every cycle from reset, so press timing adds entropy. Generated entry = one-hot(lfsr[7:0] mod N_BTN).
- IDLE -start-> GEN. mode_random is latched at this transition.
- GEN: writes one entry per cycle to addr 0..DEPTH-1, so DEPTH cycles in total. Then limit=0, addr=0, -> SHOW_ON.
- SHOW_ON: leds=mem[addr] for exactly T_ON cycles, then -> SHOW_OFF.
- SHOW_OFF: leds=0 for T_OFF cycles.
  - If addr==limit: addr=0, -> WAIT_PLAY.
  - Otherwise: addr++, -> SHOW_ON.
- WAIT_PLAY: leds = botoes (echo). Press = rising edge of OR(botoes).
  - The edge detector is cleared on entry to WAIT_PLAY. A button already held on entry does not count until it is released and pressed again.
  - On press: register botoes, -> CHECK.
  - Timeout counter clears on entry and on each press. If it reaches T_TIMEOUT-1 with no press: -> LOSE, timeout=1.
- CHECK (one cycle): compare the registered value with mem[addr]. A multi-bit press never matches.
  - Mismatch: -> LOSE, timeout=0.
  - Match and addr<limit: addr++, -> WAIT_PLAY.
  - Match and addr==limit: -> ROUND_DONE.
- ROUND_DONE (one cycle): round_ok=1.
  - If limit==DEPTH-1: -> WIN.
  - Otherwise: limit++, addr=0, -> SHOW_ON.
- WIN/LOSE: leds=0 (LOSE: all LEDs on). Hold until start, which -> GEN with a new sequence; limit resets to 0.
- start asserted in any other state is ignored.
- Simultaneous press and timeout in the same cycle: the press wins.
- reset mid-game: back to IDLE on the next edge, all outputs 0.
- Memory: DEPTH x N_BTN, synchronous write. Read is asynchronous, or registered with address prefetch; playback timing must match either way.
- db_estado encoding: IDLE 0, GEN 1, SHOW_ON 2, SHOW_OFF 3, WAIT_PLAY 4, CHECK 5, ROUND_DONE 6, WIN 7, LOSE 8.

Decomposition:
- Shared package genius_pkg holds the state codes, the LFSR tap mask, and function onehot_mod(value, n).
- One sub-module: genius_lfsr (16-bit Galois LFSR; seed parameter; synchronous reset; free-running).
- Edge detector, counters and memory stay inline.

Test Plan:
Default bench parameters: N_BTN=4, DEPTH=4, T_ON=4, T_OFF=2, T_TIMEOUT=20, mode_random=0, giving sequence 0001, 0010, 0100, 1000.
1. Basic playback: start -> GEN busy for 4 cycles, then leds=0001 for exactly 4 cycles, then 0 for 2 cycles, then player_turn=1.
2. Full game: correct presses each round -> round_ok pulses 4 times; leds show 1, 2, 3, 4 steps in successive rounds; win=1 after the 4th; db_limite stops at 3.
3. Wrong press: press 0010 in round 0 -> lose=1, timeout=0, leds=1111.
4. Timeout: no press for 20 cycles -> lose=1, timeout=1.
   - Press at cycle 19 -> CHECK proceeds with no lose.
5. Edge cases:
   - Press with 0011 -> lose.
   - Button held across entry to WAIT_PLAY -> no press registered until release and re-press.
6. Random mode: mode_random=1, reset mid-SHOW_ON -> IDLE next cycle, outputs 0.
   - Two games with different start timing -> sequences differ.
   - Every entry is one-hot.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius sequence engine: state codes, LFSR taps
// and the one-hot entry generator.
package genius_pkg;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StGen       = 4'd1,
        StShowOn    = 4'd2,
        StShowOff   = 4'd3,
        StWaitPlay  = 4'd4,
        StCheck     = 4'd5,
        StRoundDone = 4'd6,
        StWin       = 4'd7,
        StLose      = 4'd8
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] onehot_mod(input logic [15:0] value, input int unsigned n);
        int unsigned idx;
        idx = 32'(value) % n;
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every cycle outside reset.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/genius_seq_engine.sv
// Genius (Simon) sequence engine: generates a sequence, plays it back on the
// LEDs round by round and checks the player's presses with a per-press timeout.
module genius_seq_engine
    import genius_pkg::*;
#(
    parameter int unsigned N_BTN     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned T_ON      = 1000,
    parameter int unsigned T_OFF     = 500,
    parameter int unsigned T_TIMEOUT = 5000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_random,
    input  logic [N_BTN-1:0]  botoes,
    output logic [N_BTN-1:0]  leds,
    output logic              busy,
    output logic              player_turn,
    output logic              round_ok,
    output logic              win,
    output logic              lose,
    output logic              timeout,
    output logic [ADDR_W-1:0] db_limite,
    output logic [ADDR_W-1:0] db_endereco,
    output logic [3:0]        db_estado
);

    localparam int unsigned T_MAX = (T_ON > T_OFF) ?
                                    ((T_ON > T_TIMEOUT) ? T_ON : T_TIMEOUT) :
                                    ((T_OFF > T_TIMEOUT) ? T_OFF : T_TIMEOUT);
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BTN-1:0]  press_q, press_d;
    logic              mode_q, mode_d;
    logic              timeout_q, timeout_d;
    logic              prev_q;

    logic [N_BTN-1:0]  mem_q [DEPTH];
    logic              mem_we;

    logic [15:0]       lfsr_value;
    logic [7:0]        gen_full;
    logic [N_BTN-1:0]  gen_entry;
    logic              gen_unused;

    logic              any_btn;
    logic              press;
    logic              press_onehot;
    logic              match;
    logic              last_addr;

    genius_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_value)
    );

    always_comb begin
        gen_full = onehot_mod(mode_q ? {8'h00, lfsr_value[7:0]} : 16'(addr_q), N_BTN);
    end
    assign gen_entry  = gen_full[N_BTN-1:0];
    assign gen_unused = ^{lfsr_value[15:8], gen_full[7:N_BTN]};

    // prev_q tracks the OR of the buttons every cycle, so a button already held
    // when WAIT_PLAY is entered shows no rising edge until released and re-pressed.
    assign any_btn      = |botoes;
    assign press        = (state_q == StWaitPlay) && any_btn && !prev_q;
    assign press_onehot = (press_q != '0) && ((press_q & (press_q - 1'b1)) == '0);
    assign match        = press_onehot && (press_q == mem_q[addr_q]);
    assign last_addr    = (addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        limit_d   = limit_q;
        cnt_d     = cnt_q;
        press_d   = press_q;
        mode_d    = mode_q;
        timeout_d = timeout_q;
        mem_we    = 1'b0;
        leds      = '0;
        round_ok  = 1'b0;

        unique case (state_q)
            StIdle, StWin, StLose: begin
                if (state_q == StLose) begin
                    leds = '1;
                end
                if (start) begin
                    state_d   = StGen;
                    mode_d    = mode_random;
                    addr_d    = '0;
                    limit_d   = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            StGen: begin
                mem_we = 1'b1;
                if (last_addr) begin
                    addr_d  = '0;
                    limit_d = '0;
                    cnt_d   = '0;
                    state_d = StShowOn;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StShowOn: begin
                leds = mem_q[addr_q];
                if (cnt_q == CNT_W'(T_ON - 1)) begin
                    cnt_d   = '0;
                    state_d = StShowOff;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShowOff: begin
                if (cnt_q == CNT_W'(T_OFF - 1)) begin
                    cnt_d = '0;
                    if (addr_q == limit_q) begin
                        addr_d  = '0;
                        state_d = StWaitPlay;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StShowOn;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitPlay: begin
                leds = botoes;
                // A press in the last allowed cycle takes priority over the timeout.
                if (press) begin
                    press_d = botoes;
                    cnt_d   = '0;
                    state_d = StCheck;
                end else if (cnt_q == CNT_W'(T_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StLose;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (!match) begin
                    timeout_d = 1'b0;
                    state_d   = StLose;
                end else if (addr_q == limit_q) begin
                    state_d = StRoundDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StWaitPlay;
                end
            end
            StRoundDone: begin
                round_ok = 1'b1;
                if (limit_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StWin;
                end else begin
                    limit_d = limit_q + 1'b1;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = StShowOn;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            limit_q   <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
            mode_q    <= 1'b0;
            timeout_q <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            limit_q   <= limit_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            prev_q    <= any_btn;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_q] <= gen_entry;
        end
    end

    assign busy        = !((state_q == StIdle) || (state_q == StWin) || (state_q == StLose));
    assign player_turn = (state_q == StWaitPlay);
    assign win         = (state_q == StWin);
    assign lose        = (state_q == StLose);
    assign timeout     = (state_q == StLose) && timeout_q;
    assign db_limite   = limit_q;
    assign db_endereco = addr_q;
    assign db_estado   = state_q;

endmodule

// File: tb/tb_genius_seq_engine.sv
// Scoreboard bench for genius_seq_engine: stimulus queues expected playback,
// round and end-of-game events; a negedge monitor pops and compares them.
module tb_genius_seq_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode_random = 1'b0;
    logic [3:0] botoes = '0;
    logic [3:0] leds;
    logic       busy, player_turn, round_ok, win, lose, timeout;
    logic [1:0] db_limite, db_endereco;
    logic [3:0] db_estado;

    genius_seq_engine #(
        .N_BTN     (4),
        .DEPTH     (4),
        .ADDR_W    (2),
        .T_ON      (4),
        .T_OFF     (2),
        .T_TIMEOUT (20),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mode_random (mode_random),
        .botoes      (botoes),
        .leds        (leds),
        .busy        (busy),
        .player_turn (player_turn),
        .round_ok    (round_ok),
        .win         (win),
        .lose        (lose),
        .timeout     (timeout),
        .db_limite   (db_limite),
        .db_endereco (db_endereco),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] len;
        logic [3:0] leds;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] shown_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    localparam logic [3:0][3:0] DET = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // Reference LFSR built from the polynomial, tracking the DUT's reset.
    logic [15:0] mdl;
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction
    always @(posedge clock) begin
        if (reset) mdl <= 16'hACE1;
        else       mdl <= lfsr_step(mdl);
    end

    function automatic logic [3:0] oh(input logic [15:0] v);
        return 4'b0001 << (v[7:0] % 8'd4);
    endfunction

    // Start sampled next edge: GEN entry i sees the LFSR i+1 steps ahead.
    function automatic logic [3:0][3:0] predict(input logic [15:0] cur);
        logic [15:0]      v;
        logic [3:0][3:0]  s;
        v = cur;
        for (int i = 0; i < 4; i++) begin
            v    = lfsr_step(v);
            s[i] = oh(v);
        end
        return s;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'b1)) == 4'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic emit(input logic [3:0] k, input logic [7:0] l, input logic [3:0] ld);
        ev_t got, want;
        got = {k, l, ld};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got kind=%0d len=%0d leds=%b, required no event",
                     k, l, ld);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_errors++;
                $display("FAIL sb_event: got kind=%0d len=%0d leds=%b, required kind=%0d len=%0d leds=%b",
                         got.kind, got.len, got.leds, want.kind, want.len, want.leds);
            end
        end
    endtask

    // Monitor: GEN/SHOW_ON/SHOW_OFF runs (length, first-cycle LEDs), round_ok, WIN/LOSE entry.
    initial begin
        logic [3:0] prev_st, cur;
        logic [7:0] run_len;
        logic [3:0] run_leds;
        prev_st  = 4'd0;
        run_len  = 8'd0;
        run_leds = 4'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_st = 4'd0;
                run_len = 8'd0;
            end else begin
                cur = db_estado;
                if (cur != prev_st) begin
                    if (prev_st >= 4'd1 && prev_st <= 4'd3) emit(prev_st, run_len, run_leds);
                    if (prev_st == 4'd2) shown_q.push_back(run_leds);
                    run_len  = 8'd1;
                    run_leds = leds;
                    if (cur == 4'd7 || cur == 4'd8) emit(cur, {7'd0, timeout}, leds);
                    prev_st = cur;
                end else begin
                    run_len = run_len + 8'd1;
                end
                if (round_ok) emit(4'd6, {6'd0, db_limite}, 4'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int n;
        n = 0;
        while (db_estado != s && n < 300) begin
            tick;
            n++;
        end
        if (db_estado != s) chk(name, {28'd0, db_estado}, {28'd0, s});
    endtask

    task automatic push_ev(input logic [3:0] k, input logic [7:0] l, input logic [3:0] ld);
        exp_q.push_back({k, l, ld});
    endtask

    task automatic push_show(input logic [3:0][3:0] seq, input int r);
        for (int i = 0; i <= r; i++) begin
            push_ev(4'd2, 8'd4, seq[i]);
            push_ev(4'd3, 8'd2, 4'd0);
        end
    endtask

    task automatic push_full(input logic [3:0][3:0] seq);
        push_ev(4'd1, 8'd4, 4'd0);
        for (int r = 0; r < 4; r++) begin
            push_show(seq, r);
            push_ev(4'd6, 8'(r), 4'd0);
        end
        push_ev(4'd7, 8'd0, 4'd0);
    endtask

    task automatic press(input logic [3:0] v);
        wait_state(4'd4, "wait_turn");
        botoes = v;
        tick;
        botoes = '0;
    endtask

    task automatic play_full(input logic [3:0][3:0] seq);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i <= r; i++) press(seq[i]);
        end
    endtask

    task automatic do_start(input logic m);
        mode_random = m;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0][3:0] seq_a, seq_b;
        logic [3:0][3:0] obs_a, obs_b;
        logic            found;
        int              n;

        repeat (3) tick;
        reset = 1'b0;
        chk("rst_estado", {28'd0, db_estado}, 32'd0);
        chk("rst_leds", {28'd0, leds}, 32'd0);
        chk("rst_flags", {26'd0, busy, player_turn, round_ok, win, lose, timeout}, 32'd0);
        chk("rst_limite", {30'd0, db_limite}, 32'd0);
        chk("rst_endereco", {30'd0, db_endereco}, 32'd0);

        // Full deterministic game, with a start during SHOW_ON that must be ignored.
        push_full(DET);
        do_start(1'b0);
        chk("gen_busy", {31'd0, busy}, 32'd1);
        chk("gen_estado", {28'd0, db_estado}, 32'd1);
        wait_state(4'd2, "reach_show");
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_state(4'd4, "reach_wait");
        chk("player_turn", {31'd0, player_turn}, 32'd1);
        play_full(DET);
        wait_state(4'd7, "reach_win");
        chk("win_level", {31'd0, win}, 32'd1);
        chk("win_limite", {30'd0, db_limite}, 32'd3);
        chk("win_not_busy", {31'd0, busy}, 32'd0);

        // Wrong button in round 0.
        push_ev(4'd1, 8'd4, 4'd0);
        push_show(DET, 0);
        push_ev(4'd8, 8'd0, 4'hF);
        do_start(1'b0);
        press(4'b0010);
        wait_state(4'd8, "reach_lose_wrong");
        chk("wrong_lose", {31'd0, lose}, 32'd1);
        chk("wrong_timeout", {31'd0, timeout}, 32'd0);
        chk("wrong_leds", {28'd0, leds}, 32'hF);

        // No press: timeout after exactly 20 cycles in WAIT_PLAY.
        push_ev(4'd1, 8'd4, 4'd0);
        push_show(DET, 0);
        push_ev(4'd8, 8'd1, 4'hF);
        do_start(1'b0);
        wait_state(4'd4, "reach_wait_to");
        repeat (19) tick;
        chk("to_still_waiting", {28'd0, db_estado}, 32'd4);
        tick;
        chk("to_lose_state", {28'd0, db_estado}, 32'd8);
        chk("to_timeout_flag", {31'd0, timeout}, 32'd1);

        // Press in the last cycle, held button across entry, then a two-bit press.
        push_ev(4'd1, 8'd4, 4'd0);
        push_show(DET, 0);
        push_ev(4'd6, 8'd0, 4'd0);
        push_show(DET, 1);
        push_ev(4'd6, 8'd1, 4'd0);
        push_show(DET, 2);
        push_ev(4'd8, 8'd0, 4'hF);
        do_start(1'b0);
        wait_state(4'd4, "reach_wait_late");
        repeat (19) tick;
        botoes = 4'b0001;
        tick;
        chk("late_press_check", {28'd0, db_estado}, 32'd5);
        botoes = '0;
        wait_state(4'd3, "reach_show_off_r1");
        botoes = 4'b0001;
        wait_state(4'd4, "reach_wait_held");
        repeat (5) tick;
        chk("held_no_press", {28'd0, db_estado}, 32'd4);
        chk("held_echo", {28'd0, leds}, 32'd1);
        botoes = '0;
        tick;
        press(4'b0001);
        press(4'b0010);
        press(4'b0011);
        wait_state(4'd8, "reach_lose_multi");
        chk("multi_lose", {31'd0, lose}, 32'd1);
        chk("multi_timeout", {31'd0, timeout}, 32'd0);

        // Random mode: reset during SHOW_ON.
        push_ev(4'd1, 8'd4, 4'd0);
        do_start(1'b1);
        mode_random = 1'b0;
        wait_state(4'd2, "reach_show_rand");
        repeat (2) tick;
        reset = 1'b1;
        tick;
        chk("midrst_estado", {28'd0, db_estado}, 32'd0);
        chk("midrst_leds", {28'd0, leds}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Random game A, then game B started at a moment giving a different sequence.
        repeat (3) tick;
        seq_a = predict(mdl);
        push_full(seq_a);
        do_start(1'b1);
        mode_random = 1'b0;
        play_full(seq_a);
        wait_state(4'd7, "reach_win_a");
        chk("win_a", {31'd0, win}, 32'd1);
        n = shown_q.size();
        obs_a = '0;
        if (n >= 4) for (int i = 0; i < 4; i++) obs_a[i] = shown_q[n - 4 + i];
        for (int i = 0; i < 4; i++) chk($sformatf("onehot_a%0d", i), {31'd0, is_onehot(obs_a[i])}, 32'd1);

        found = 1'b0;
        seq_b = '0;
        for (int k = 0; k < 50 && !found; k++) begin
            seq_b = predict(mdl);
            if (seq_b != seq_a) found = 1'b1;
            else tick;
        end
        chk("seq_b_search", {31'd0, found}, 32'd1);
        push_full(seq_b);
        do_start(1'b1);
        mode_random = 1'b0;
        play_full(seq_b);
        wait_state(4'd7, "reach_win_b");
        n = shown_q.size();
        obs_b = '0;
        if (n >= 4) for (int i = 0; i < 4; i++) obs_b[i] = shown_q[n - 4 + i];
        for (int i = 0; i < 4; i++) chk($sformatf("onehot_b%0d", i), {31'd0, is_onehot(obs_b[i])}, 32'd1);
        chk("seq_differs", {31'd0, (obs_a != obs_b)}, 32'd1);

        repeat (5) tick;
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
